// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one single-byte UART transmitter between NREQ requesters.
//   Arbitration is round-robin. A requester may hold req_lock so that its next
//   byte is granted before anyone else's. For each byte the block drives the
//   transmitter handshake: a one-cycle tx_en pulse, then a wait for tx_status
//   to fall (shifting), then a wait for it to rise again (done).
//
//   Optional feature: define INTER_BYTE_GAP_EN to add a GAP state after each
//   byte. The GAP state keeps busy high for GAP_CYC idle cycles.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req          per-requester byte request, held until its ack
//   req_lock     keep the grant for the requester's next byte
//   req_data     byte i on bits [8i+7:8i]
//   ack          one-cycle pulse: byte accepted and launched
//   grant_id     index of the requester currently or last served
//   tx_en        one-cycle start pulse to the transmitter
//   tx_data      byte to the transmitter, held until the next launch
//   tx_status    transmitter idle flag (1 = idle, 0 = shifting)
//   busy         high whenever the FSM is not in IDLE
//   err          sticky WAIT_BUSY timeout flag
//   err_clr      clears err; a timeout in the same cycle takes priority
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned BUSY_TO = 8,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [IDW-1:0]    grant_id,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_status,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    localparam int unsigned CNT_MAX = (BUSY_TO > GAP_CYC) ? BUSY_TO : GAP_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
`ifdef INTER_BYTE_GAP_EN
        , GAP
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            lock_hold_q, lock_hold_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  idx;
    logic [7:0]      win_data;
    logic            timeout;

    // Winner selection. A live lock on the last grantee overrides the scan.
    // Otherwise the scan starts just after rr_ptr and wraps.
    always_comb begin
        found  = 1'b0;
        winner = grant_id_q;
        idx    = '0;
        if (lock_hold_q && req[grant_id_q]) begin
            found = 1'b1;
        end else begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                idx = IDW'((32'(rr_ptr_q) + i) % NREQ);
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
        end
        win_data = req_data[{winner, 3'b000} +: 8];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        lock_hold_d = lock_hold_q;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        timeout     = 1'b0;
        tx_en       = 1'b0;
        ack         = '0;

        case (state_q)
            IDLE: begin
                // A lock whose owner has dropped req is released here.
                // In the same cycle, arbitration falls back to the scan.
                if (lock_hold_q && !req[grant_id_q]) begin
                    lock_hold_d = 1'b0;
                end
                // Wait for tx_status high. After a reset the transmitter may
                // still be shifting a byte.
                if (tx_status && found) begin
                    tx_data_d   = win_data;
                    grant_id_d  = winner;
                    rr_ptr_d    = winner;
                    lock_hold_d = req_lock[winner];
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en           = 1'b1;
                ack[grant_id_q] = 1'b1;
                cnt_d           = '0;
                state_d         = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_status) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TO - 1)) begin
                    timeout     = 1'b1;
                    lock_hold_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_status) begin
`ifdef INTER_BYTE_GAP_EN
                    cnt_d   = '0;
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef INTER_BYTE_GAP_EN
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            grant_id_q  <= '0;
            lock_hold_q <= 1'b0;
            tx_data_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            lock_hold_q <= lock_hold_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant_id = grant_id_q;
    assign tx_data  = tx_data_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios with hand-computed values.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned BUSY_TO = 8;
    localparam int unsigned GAP_CYC = 2;
`ifdef INTER_BYTE_GAP_EN
    localparam int GAP_EXTRA = GAP_CYC;
`else
    localparam int GAP_EXTRA = 0;
`endif
    localparam int L2L      = 13 + GAP_EXTRA;
    localparam int BUSY_LEN = 12 + GAP_EXTRA;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_lock;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [IDW-1:0]    grant_id;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_status = 1'b1;
    logic              busy;
    logic              err;
    logic              err_clr;

    logic              tx_stuck = 1'b0;
    int                tx_cnt   = 0;

    int n_run  = 0;
    int n_fail = 0;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .BUSY_TO (BUSY_TO),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_lock  (req_lock),
        .req_data  (req_data),
        .ack       (ack),
        .grant_id  (grant_id),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_status (tx_status),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: after tx_en, tx_status is low for 10 cycles. It is
    // never reset. When tx_stuck is set it ignores tx_en.
    always @(posedge clk) begin
        if (tx_en && !tx_stuck) begin
            tx_status <= 1'b0;
            tx_cnt    <= 10;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_status <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    // Advances at least one cycle, then stops at the first negedge with tx_en high.
    task automatic wait_tx(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_en && n < 60);
        check({tag, "_launch"}, tx_en, 1);
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((busy || !tx_status) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("quiet", busy, 0);
    endtask

    task automatic do_reset();
        req      = '0;
        req_lock = '0;
        req_data = '0;
        err_clr  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int b;
        int pulses;
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};

        rst_n    = 1'b0;
        req      = '0;
        req_lock = '0;
        req_data = '0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ack",     ack,      0);
        check("rst_tx_en",   tx_en,    0);
        check("rst_tx_data", tx_data,  8'h00);
        check("rst_grant",   grant_id, 0);
        check("rst_busy",    busy,     0);
        check("rst_err",     err,      0);

        // Single requester
        set_byte(0, 8'hA5);
        req = 4'b0001;
        wait_tx("single", n);
        check("single_lat",   n,        1);
        check("single_data",  tx_data,  8'hA5);
        check("single_ack",   ack,      4'b0001);
        check("single_grant", grant_id, 0);
        req = '0;
        b = 0;
        pulses = 0;
        while (busy && b < 40) begin
            if (tx_en) pulses++;
            b++;
            @(negedge clk);
        end
        check("single_busy",   b,      BUSY_LEN);
        check("single_pulses", pulses, 1);
        check("single_err",    err,    0);
        wait_quiet();

        // Round-robin with all requesters active
        do_reset();
        for (int i = 0; i < 4; i++) set_byte(i, 8'h10 + 8'(i));
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_tx("rr", n);
            if (k == 0) check("rr_lat", n, 1);
            else        check("rr_l2l", n, L2L);
            check("rr_grant", grant_id, exp_order[k]);
            check("rr_ack",   ack,      1 << exp_order[k]);
            check("rr_data",  tx_data,  8'h10 + exp_order[k]);
        end
        req = '0;
        wait_quiet();

        // Lock: requester 2 sends three bytes back to back
        do_reset();
        set_byte(2, 8'h11);
        set_byte(0, 8'hC0);
        req_lock = 4'b0100;
        req      = 4'b0100;
        wait_tx("lock1", n);
        check("lock1_grant", grant_id, 2);
        check("lock1_data",  tx_data,  8'h11);
        set_byte(2, 8'h22);
        req = 4'b0101;
        wait_tx("lock2", n);
        check("lock2_l2l",   n,        L2L);
        check("lock2_grant", grant_id, 2);
        check("lock2_data",  tx_data,  8'h22);
        set_byte(2, 8'h33);
        req_lock = '0;
        wait_tx("lock3", n);
        check("lock3_grant", grant_id, 2);
        check("lock3_data",  tx_data,  8'h33);
        req = 4'b0001;
        wait_tx("lock4", n);
        check("lock4_grant", grant_id, 0);
        check("lock4_data",  tx_data,  8'hC0);
        check("lock4_ack",   ack,      4'b0001);
        req = '0;
        wait_quiet();

        // Timeout: transmitter never goes busy
        do_reset();
        tx_stuck = 1'b1;
        set_byte(0, 8'h3C);
        req = 4'b0001;
        wait_tx("to1", n);
        req = '0;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!err && b < 30);
        check("to_delay", b,    BUSY_TO + 1);
        check("to_err",   err,  1);
        check("to_idle",  busy, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_clr", err, 0);
        req = 4'b0001;
        wait_tx("to2", n);
        req = '0;
        repeat (BUSY_TO) @(negedge clk);
        check("to_pre", err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_simul", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_clr2", err, 0);
        tx_stuck = 1'b0;

        // Reset while the transmitter is shifting
        do_reset();
        set_byte(0, 8'h5A);
        req = 4'b0001;
        wait_tx("mid0", n);
        req = '0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_byte(1, 8'h77);
        req = 4'b0010;
        wait_tx("mid1", n);
        check("mid_wait",  n,        7);
        check("mid_grant", grant_id, 1);
        check("mid_data",  tx_data,  8'h77);
        check("mid_ack",   ack,      4'b0010);
        req = '0;
        wait_quiet();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_byte(0, 8'h5A);
        req = 4'b0011;
        wait_tx("mid2", n);
        check("mid2_grant", grant_id, 0);
        check("mid2_data",  tx_data,  8'h5A);
        req = '0;
        wait_quiet();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single-byte UART transmitter between NREQ independent requesters.
- Arbitration is round-robin, with an optional per-requester lock for multi-byte messages.
- Sequences the transmitter handshake: one-cycle enable pulse, wait for status low (busy), wait for status high (done).
- Sits between client logic (command responders, debug dumpers) and the transmitter. Runs on the transmitter's clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant index; must equal ceil(log2(NREQ)).
- BUSY_TO, 8, cycles allowed in WAIT_BUSY for tx_status to fall before a timeout error.
- GAP_CYC, 2, idle cycles inserted between bytes (used only with INTER_BYTE_GAP_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester byte request; held until its ack.
- req_lock  in  NREQ  keep the grant for the next byte from the same requester.
- req_data  in  8*NREQ  byte i on bits [8i+7:8i]; stable while req[i] is high.
- ack  out  NREQ  one-cycle pulse; byte accepted and launched.
- grant_id  out  IDW  index of the requester currently or last served.
- tx_en  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to the transmitter; held from LAUNCH until the next launch.
- tx_status  in  1  transmitter idle flag: 1 = idle, 0 = shifting.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err. A timeout occurring in the same cycle has priority and sets err.

Behaviour:
- Reset values: ack=0, tx_en=0, tx_data=8'h00, grant_id=0, busy=0, err=0, state=IDLE, rr_ptr=NREQ-1 (so requester 0 wins first), lock_hold=0.
- Reset is asynchronous and may occur mid-byte. The transmitter itself is not reset, so the IDLE guard below prevents overlapping a byte that is still shifting.
- IDLE:
  - Arbitrate only when tx_status==1 and req!=0.
  - Winner: if lock_hold is set and req[grant_id]==1, grant_id wins again. Otherwise the first set req bit scanning from rr_ptr+1 upward, wrapping at NREQ-1 to 0.
  - On arbitration: latch req_data[winner] into tx_data, set grant_id=winner, set rr_ptr=winner, set lock_hold=req_lock[winner], go to LAUNCH.
  - If lock_hold is set but req[grant_id]==0, clear lock_hold and arbitrate normally in the same cycle.
- LAUNCH (1 cycle): tx_en=1, ack[grant_id]=1, then go to WAIT_BUSY.
  - The requester may change req and req_data from the cycle after ack.
  - Latency from req sampled high in IDLE to tx_en high is 1 cycle.
- WAIT_BUSY: a counter starts at 0.
  - tx_status==0 -> WAIT_DONE.
  - Counter reaches BUSY_TO-1 with tx_status still 1 -> set err, clear lock_hold, go to IDLE.
- WAIT_DONE: tx_status==1 -> GAP if INTER_BYTE_GAP_EN is defined, otherwise IDLE. No timeout in this state.
- Throughput without gap: launch-to-launch is 13 cycles against the 10-cycle transmitter (LAUNCH, 1 WAIT_BUSY, 10 WAIT_DONE, 1 IDLE).
- Only one ack bit is ever high. ack is never asserted for a requester whose req was low when sampled.
- A requester dropping req before its ack is legal: the request is withdrawn with no ack. If it drops in the IDLE sample cycle it is not granted.
- tx_en is never high unless state==LAUNCH. Two tx_en pulses are never closer than one full status low/high cycle, except after a timeout.

Optional Feature:
- INTER_BYTE_GAP_EN defined: a GAP state follows WAIT_DONE, holds busy=1, counts GAP_CYC cycles, then returns to IDLE. Launch-to-launch becomes 13+GAP_CYC cycles. A locked requester still waits for the gap.
- INTER_BYTE_GAP_EN undefined: no GAP state, GAP_CYC is ignored, and WAIT_DONE returns directly to IDLE.

Test Plan:
- Single requester: req[0]=1, data 8'hA5, transmitter model idles 10 cycles -> one tx_en pulse with tx_data=8'hA5, ack[0] in the same cycle, busy high for 12 cycles, err=0.
- Round-robin: req=4'b1111 held, each requester re-requests after its ack -> grant order 0,1,2,3,0,1; no requester served twice in a row.
- Lock: req[2]=1 with req_lock[2]=1 for 3 bytes (11,22,33), req[0]=1 throughout -> bytes 11,22,33 from requester 2 back to back, then requester 0 is served.
- Timeout: transmitter model keeps tx_status=1 -> err=1 exactly BUSY_TO cycles after WAIT_BUSY entry, return to IDLE. err_clr pulse -> err=0. Simultaneous timeout and err_clr -> err=1.
- Reset mid-byte: assert rst_n=0 during WAIT_DONE while the transmitter is shifting, release, req[1]=1 -> no tx_en until tx_status returns to 1; first grant goes to requester 1 only if req[0]=0.
- With INTER_BYTE_GAP_EN and GAP_CYC=2: two consecutive bytes -> launch-to-launch interval of 15 cycles.
